// File: rtl/fft16_pkg.sv
// Shared types and constants for the 16-point streaming FFT wrapper.
// Twiddles are Q16.16 values of cos/sin(2*pi*k/16), k = 0..7.
package fft16_pkg;

    localparam int N_PTS = 16;
    localparam int W     = 32;

    localparam logic [31:0] ONE = 32'h0001_0000;

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        UNLOAD
    } state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic signed [17:0] tw_cos(input logic [2:0] k);
        logic signed [17:0] r;
        unique case (k)
            3'd0: r = 18'sd65536;
            3'd1: r = 18'sd60547;
            3'd2: r = 18'sd46341;
            3'd3: r = 18'sd25080;
            3'd4: r = 18'sd0;
            3'd5: r = -18'sd25080;
            3'd6: r = -18'sd46341;
            default: r = -18'sd60547;
        endcase
        return r;
    endfunction

    function automatic logic signed [17:0] tw_sin(input logic [2:0] k);
        logic signed [17:0] r;
        unique case (k)
            3'd0: r = 18'sd0;
            3'd1: r = 18'sd25080;
            3'd2: r = 18'sd46341;
            3'd3: r = 18'sd60547;
            3'd4: r = 18'sd65536;
            3'd5: r = 18'sd60547;
            3'd6: r = 18'sd46341;
            default: r = 18'sd25080;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fft16_stream_ctrl_core.sv
// Combinational 16-point radix-2 DIF FFT on Q16.16 complex samples.
// Natural-order input bus, natural-order output bus (bit reversal inside).
module fft16_stream_ctrl_core #(
    parameter int W = 32
) (
    input  logic [16*W-1:0] in_re,
    input  logic [16*W-1:0] in_im,
    output logic [16*W-1:0] out_re,
    output logic [16*W-1:0] out_im
);
    import fft16_pkg::*;

    logic signed [W-1:0]  xr [N_PTS];
    logic signed [W-1:0]  xi [N_PTS];
    logic signed [W-1:0]  sr, si, dr, di;
    logic signed [W+17:0] pr, pi;
    logic signed [17:0]   c, sn;
    int                   b;
    int                   half;

    always_comb begin
        sr   = '0;
        si   = '0;
        dr   = '0;
        di   = '0;
        pr   = '0;
        pi   = '0;
        c    = '0;
        sn   = '0;
        b    = 0;
        half = 0;
        out_re = '0;
        out_im = '0;
        for (int k = 0; k < N_PTS; k++) begin
            xr[k] = in_re[k*W +: W];
            xi[k] = in_im[k*W +: W];
        end
        // In-place butterflies; the twiddle is applied to the difference leg.
        for (int s = 0; s < 4; s++) begin
            half = 8 >> s;
            for (int a = 0; a < N_PTS; a++) begin
                if ((a & half) == 0) begin
                    b  = a | half;
                    c  = tw_cos(3'((a & (half - 1)) << s));
                    sn = tw_sin(3'((a & (half - 1)) << s));
                    sr = xr[a] + xr[b];
                    si = xi[a] + xi[b];
                    dr = xr[a] - xr[b];
                    di = xi[a] - xi[b];
                    pr = (W+18)'(dr) * (W+18)'(c)
                       + (W+18)'(di) * (W+18)'(sn);
                    pi = (W+18)'(di) * (W+18)'(c)
                       - (W+18)'(dr) * (W+18)'(sn);
                    xr[a] = sr;
                    xi[a] = si;
                    xr[b] = W'(pr >>> 16);
                    xi[b] = W'(pi >>> 16);
                end
            end
        end
        for (int k = 0; k < N_PTS; k++) begin
            out_re[k*W +: W] = xr[bitrev4(4'(k))];
            out_im[k*W +: W] = xi[bitrev4(4'(k))];
        end
    end

endmodule

// File: rtl/fft16_stream_ctrl.sv
// Streaming wrapper around the 16-point FFT core: load 16 samples,
// wait CALC_CYCLES for the core to settle, then unload 16 bins.
module fft16_stream_ctrl #(
    parameter int CALC_CYCLES = 2,
    parameter int W           = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_re,
    input  logic [W-1:0] s_im,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_re,
    output logic [W-1:0] m_im,
    output logic [3:0]   m_idx,
    output logic         m_last,
    output logic         busy,
    output logic [15:0]  frames
);
    import fft16_pkg::*;

    state_t            state;
    logic [3:0]        load_cnt;
    logic [3:0]        calc_cnt;
    logic [16*W-1:0]   buf_re;
    logic [16*W-1:0]   buf_im;
    logic [16*W-1:0]   core_re;
    logic [16*W-1:0]   core_im;
    logic [W-1:0]      obuf_re [N_PTS];
    logic [W-1:0]      obuf_im [N_PTS];
    logic              s_hs;
    logic              m_hs;
    logic              calc_done;
    logic              capture;
    logic [3:0]        idx_nxt;

    assign s_hs      = s_valid & s_ready;
    assign m_hs      = m_valid & m_ready;
    assign calc_done = (calc_cnt == 4'(CALC_CYCLES - 1));
    assign capture   = (state == CALC) && calc_done && !clr;
    assign idx_nxt   = m_idx + 4'd1;
    assign busy      = (state != LOAD) || (load_cnt != 4'd0);

    fft16_stream_ctrl_core #(
        .W(W)
    ) u_core (
        .in_re (buf_re),
        .in_im (buf_im),
        .out_re(core_re),
        .out_im(core_im)
    );

    // Data buffers carry no reset; only the control state is cleared.
    always_ff @(posedge clk) begin
        if (s_hs) begin
            buf_re[load_cnt*W +: W] <= s_re;
            buf_im[load_cnt*W +: W] <= s_im;
        end
        if (capture) begin
            for (int k = 0; k < N_PTS; k++) begin
                obuf_re[k] <= core_re[k*W +: W];
                obuf_im[k] <= core_im[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            load_cnt <= 4'd0;
            calc_cnt <= 4'd0;
            m_idx    <= 4'd0;
            frames   <= 16'd0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_re     <= '0;
            m_im     <= '0;
        end else if (clr) begin
            state    <= LOAD;
            load_cnt <= 4'd0;
            calc_cnt <= 4'd0;
            m_idx    <= 4'd0;
            s_ready  <= 1'b1;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (s_hs) begin
                        if (load_cnt == 4'd15) begin
                            state    <= CALC;
                            load_cnt <= 4'd0;
                            calc_cnt <= 4'd0;
                            s_ready  <= 1'b0;
                        end else begin
                            load_cnt <= load_cnt + 4'd1;
                        end
                    end
                end
                CALC: begin
                    if (calc_done) begin
                        state    <= UNLOAD;
                        calc_cnt <= 4'd0;
                        m_valid  <= 1'b1;
                        m_idx    <= 4'd0;
                        m_last   <= 1'b0;
                        m_re     <= core_re[W-1:0];
                        m_im     <= core_im[W-1:0];
                    end else begin
                        calc_cnt <= calc_cnt + 4'd1;
                    end
                end
                UNLOAD: begin
                    if (m_hs) begin
                        if (m_last) begin
                            state   <= LOAD;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            m_idx   <= 4'd0;
                            s_ready <= 1'b1;
                            frames  <= frames + 16'd1;
                        end else begin
                            m_idx  <= idx_nxt;
                            m_last <= (idx_nxt == 4'd15);
                            m_re   <= obuf_re[idx_nxt];
                            m_im   <= obuf_im[idx_nxt];
                        end
                    end
                end
                default: begin
                    state   <= LOAD;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft16_stream_ctrl.sv
// Directed bench for fft16_stream_ctrl: impulse, DC, shifted impulse
// with backpressure, abort, mid-unload reset and frame-counter wrap.
module tb_fft16_stream_ctrl;
    import fft16_pkg::*;

    localparam int CC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_re = '0;
    logic [31:0] s_im = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_re;
    logic [31:0] m_im;
    logic [3:0]  m_idx;
    logic        m_last;
    logic        busy;
    logic [15:0] frames;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] in_re  [16];
    logic [31:0] in_im  [16];
    logic [31:0] exp_re [16];
    logic [31:0] exp_im [16];

    fft16_stream_ctrl #(
        .CALC_CYCLES(CC),
        .W(32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_re   (s_re),
        .s_im   (s_im),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_re   (m_re),
        .m_im   (m_im),
        .m_idx  (m_idx),
        .m_last (m_last),
        .busy   (busy),
        .frames (frames)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic load_impulse(input int pos);
        for (int k = 0; k < 16; k++) begin
            in_re[k] = (k == pos) ? ONE : 32'h0;
            in_im[k] = 32'h0;
        end
    endtask

    task automatic push_frame(input int n);
        int g;
        for (int k = 0; k < n; k++) begin
            g = 0;
            s_valid = 1'b1;
            s_re = in_re[k];
            s_im = in_im[k];
            while (!s_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            check($sformatf("s_ready_smp%0d", k), 32'(s_ready), 1);
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic pull_frame(input int stall_bin, input int stall_len,
                              input int stop_bin);
        m_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            if (b == stop_bin) return;
            check($sformatf("bin%0d_valid", b), 32'(m_valid), 1);
            check($sformatf("bin%0d_idx", b), 32'(m_idx), b);
            check($sformatf("bin%0d_re", b), m_re, exp_re[b]);
            check($sformatf("bin%0d_im", b), m_im, exp_im[b]);
            check($sformatf("bin%0d_last", b), 32'(m_last),
                  (b == 15) ? 1 : 0);
            check($sformatf("bin%0d_sready", b), 32'(s_ready), 0);
            if (b == stall_bin) begin
                m_ready = 1'b0;
                for (int i = 0; i < stall_len; i++) begin
                    @(negedge clk);
                    check($sformatf("stall%0d_valid", i), 32'(m_valid), 1);
                    check($sformatf("stall%0d_idx", i), 32'(m_idx), b);
                    check($sformatf("stall%0d_re", i), m_re, exp_re[b]);
                    check($sformatf("stall%0d_im", i), m_im, exp_im[b]);
                end
                m_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("post_frame_valid", 32'(m_valid), 0);
        check("post_frame_sready", 32'(s_ready), 1);
    endtask

    task automatic wait_first_bin();
        int cnt;
        check("calc_sready", 32'(s_ready), 0);
        check("calc_mvalid", 32'(m_valid), 0);
        check("calc_busy", 32'(busy), 1);
        cnt = 0;
        while (!m_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("latency", cnt, CC);
    endtask

    task automatic run_frame(input logic [15:0] want_frames,
                             input int stall_bin, input int stall_len);
        push_frame(16);
        wait_first_bin();
        pull_frame(stall_bin, stall_len, 99);
        check("frames", 32'(frames), 32'(want_frames));
    endtask

    initial begin
        int seen;

        // Reset values while rst_n is low.
        repeat (2) @(negedge clk);
        check("rst_sready", 32'(s_ready), 0);
        check("rst_mvalid", 32'(m_valid), 0);
        check("rst_mlast", 32'(m_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frames", 32'(frames), 0);
        check("rst_midx", 32'(m_idx), 0);
        check("rst_mre", m_re, 0);
        check("rst_mim", m_im, 0);
        rst_n = 1'b1;
        check("rel_sready_pre", 32'(s_ready), 0);
        @(negedge clk);
        check("rel_sready_post", 32'(s_ready), 1);

        // Impulse at sample 0: every bin is (1.0, 0).
        load_impulse(0);
        for (int k = 0; k < 16; k++) begin
            exp_re[k] = ONE;
            exp_im[k] = 32'h0;
        end
        run_frame(16'd1, -1, 0);

        // DC: bin 0 collects 16.0, the rest are exactly zero.
        for (int k = 0; k < 16; k++) begin
            in_re[k]  = ONE;
            in_im[k]  = 32'h0;
            exp_re[k] = (k == 0) ? 32'h0010_0000 : 32'h0;
            exp_im[k] = 32'h0;
        end
        push_frame(5);
        check("load_busy", 32'(busy), 1);
        push_frame(0);
        for (int k = 5; k < 16; k++) begin
            in_re[k - 5] = ONE;
        end
        push_frame(11);
        wait_first_bin();
        pull_frame(-1, 0, 99);
        check("frames_dc", 32'(frames), 2);

        // Impulse at sample 4: X[k] = (-j)^k, with a 5-cycle stall at bin 3.
        load_impulse(4);
        for (int k = 0; k < 16; k++) begin
            unique case (k % 4)
                0: begin exp_re[k] = ONE;          exp_im[k] = 32'h0; end
                1: begin exp_re[k] = 32'h0;        exp_im[k] = 32'hFFFF_0000; end
                2: begin exp_re[k] = 32'hFFFF_0000; exp_im[k] = 32'h0; end
                default: begin exp_re[k] = 32'h0;  exp_im[k] = ONE; end
            endcase
        end
        run_frame(16'd3, 3, 5);

        // Abort after 7 junk samples, then a clean impulse frame.
        for (int k = 0; k < 16; k++) begin
            in_re[k] = $urandom;
            in_im[k] = $urandom;
        end
        push_frame(7);
        check("abort_busy_pre", 32'(busy), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_sready", 32'(s_ready), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_mvalid", 32'(m_valid), 0);
        check("abort_frames", 32'(frames), 3);
        load_impulse(0);
        for (int k = 0; k < 16; k++) begin
            exp_re[k] = ONE;
            exp_im[k] = 32'h0;
        end
        run_frame(16'd4, -1, 0);

        // Reset while bin 8 is on the output.
        push_frame(16);
        wait_first_bin();
        pull_frame(-1, 0, 8);
        check("mid_idx", 32'(m_idx), 8);
        rst_n = 1'b0;
        m_ready = 1'b0;
        #1;
        check("mid_rst_mvalid", 32'(m_valid), 0);
        check("mid_rst_frames", 32'(frames), 0);
        check("mid_rst_sready", 32'(s_ready), 0);
        check("mid_rst_midx", 32'(m_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rel_sready_pre", 32'(s_ready), 0);
        @(negedge clk);
        check("mid_rel_sready_post", 32'(s_ready), 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        check("mid_no_output", seen, 0);

        // Frame counter wrap from 0xFFFF.
        force dut.frames = 16'hFFFF;
        @(negedge clk);
        release dut.frames;
        @(negedge clk);
        check("wrap_pre", 32'(frames), 32'h0000_FFFF);
        run_frame(16'h0000, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
